// File: rtl/vga_frame_capture.sv
// Frame-capture engine: after an arm pulse, skips FRAME_START frames, then streams
// MAX_FRAMES frames of RGB888 pixels with coordinates through a small output FIFO.
module vga_frame_capture #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned COLOR_BITS  = 1,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_START = 10,
  parameter int unsigned MAX_FRAMES  = 30
) (
  input  logic                            I_CLK,
  input  logic                            I_RESET,
  input  logic                            I_PIX_EN,
  input  logic                            I_DISPLAY_DATA,
  input  logic                            I_DRAW_FINISH,
  input  logic [COLOR_BITS-1:0]           I_RED,
  input  logic [COLOR_BITS-1:0]           I_GREEN,
  input  logic [COLOR_BITS-1:0]           I_BLUE,
  input  logic                            I_ARM,
  input  logic                            I_PIX_READY,
  output logic                            O_PIX_VALID,
  output logic [23:0]                     O_PIX_DATA,
  output logic [$clog2(WIDTH)-1:0]        O_PIX_X,
  output logic [$clog2(HEIGHT)-1:0]       O_PIX_Y,
  output logic                            O_PIX_LAST,
  output logic [$clog2(MAX_FRAMES+1)-1:0] O_FRAME_IDX,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic                            O_OVERFLOW,
  output logic                            O_SIZE_ERR
);
  localparam int unsigned XW   = $clog2(WIDTH);
  localparam int unsigned YW   = $clog2(HEIGHT);
  localparam int unsigned FW   = $clog2(MAX_FRAMES + 1);
  localparam int unsigned SW   = (FRAME_START > 0) ? $clog2(FRAME_START + 1) : 1;
  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned CW   = $clog2(NPIX + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [23:0]   rgb;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
    logic [FW-1:0] fidx;
  } pix_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CAPTURE, ST_DONE} state_t;

  // MSB-align a channel to 8 bits, replicating its bits downward
  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int unsigned i = 0; i < 8; i++) e[7-i] = c[COLOR_BITS-1-(i%COLOR_BITS)];
    return e;
  endfunction

  state_t          state, state_nxt;
  logic            busy, done;
  logic            pix_q, fin_q;
  logic            arm_go, skip_fin, cap_pix, cap_fin;
  logic [SW-1:0]   skip_cnt, skip_inc;
  logic [FW-1:0]   frame_idx;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   cnt;
  logic            frame_full;
  logic            size_err, overflow;
  logic            stg_vld;
  pix_t            stg, head;
  pix_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]     fifo_cnt, fifo_cnt_nxt;
  logic            pix_valid, pop, push, drop;

  // Frame end has priority over a pixel in the same enabled cycle
  assign pix_q      = I_PIX_EN && I_DISPLAY_DATA && !I_DRAW_FINISH;
  assign fin_q      = I_PIX_EN && I_DRAW_FINISH;
  assign skip_inc   = skip_cnt + SW'(1);
  assign frame_full = (cnt == CW'(NPIX));

  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    skip_fin  = 1'b0;
    cap_pix   = 1'b0;
    cap_fin   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (I_ARM) begin
          arm_go    = 1'b1;
          state_nxt = (FRAME_START > 0) ? ST_SKIP : ST_CAPTURE;
        end
      end
      ST_SKIP: begin
        if (fin_q) begin
          skip_fin = 1'b1;
          if (skip_inc == SW'(FRAME_START)) state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cap_pix = pix_q;
        cap_fin = fin_q;
        if (fin_q && frame_idx == FW'(MAX_FRAMES - 1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_SKIP) || (state_nxt == ST_CAPTURE);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Frame/pixel counters; saturate once a frame holds WIDTH*HEIGHT pixels
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      skip_cnt  <= '0;
      frame_idx <= '0;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      size_err  <= 1'b0;
    end else if (arm_go) begin
      skip_cnt  <= '0;
      frame_idx <= '0;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      size_err  <= 1'b0;
    end else if (skip_fin) begin
      skip_cnt <= skip_inc;
    end else if (cap_fin) begin
      if (!frame_full) size_err <= 1'b1;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      frame_idx <= frame_idx + FW'(1);
    end else if (cap_pix) begin
      if (frame_full) begin
        size_err <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
        if (x == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      stg_vld <= 1'b0;
      stg     <= '0;
    end else begin
      stg_vld <= cap_pix && !frame_full;
      if (cap_pix && !frame_full) begin
        stg.rgb  <= {expand(I_RED), expand(I_GREEN), expand(I_BLUE)};
        stg.x    <= x;
        stg.y    <= y;
        stg.last <= (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
        stg.fidx <= frame_idx;
      end
    end
  end

  // A pop in the same cycle frees a slot for a push into a full FIFO
  always_comb begin
    pop          = pix_valid && I_PIX_READY;
    push         = stg_vld && ((fifo_cnt != (AW+1)'(FIFO_DEPTH)) || pop);
    drop         = stg_vld && !push;
    rd_nxt       = rd_ptr + AW'(pop);
    fifo_cnt_nxt = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge I_CLK) begin
    if (push) mem[wr_ptr] <= stg;
  end

  // Head register is refilled from memory, or bypassed when the push lands at the head
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_valid <= 1'b0;
      head      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      pix_valid <= (fifo_cnt_nxt != '0);
      head      <= (push && wr_ptr == rd_nxt) ? stg : mem[rd_nxt];
      if (arm_go)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign O_PIX_VALID = pix_valid;
  assign O_PIX_DATA  = head.rgb;
  assign O_PIX_X     = head.x;
  assign O_PIX_Y     = head.y;
  assign O_PIX_LAST  = head.last;
  assign O_FRAME_IDX = head.fidx;
  assign O_BUSY      = busy;
  assign O_DONE      = done;
  assign O_OVERFLOW  = overflow;
  assign O_SIZE_ERR  = size_err;

endmodule
